// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note events onto NUM_VOICES generators and runs a
// linear attack/sustain/release amplitude envelope per voice.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned TICK_DIV   = 50000,
  parameter logic [30:0] AMP_MAX    = 31'h7FFFFFFF,
  parameter logic [30:0] AMP_STEP   = 31'd2147484
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ev_valid,
  output logic                       ev_ready,
  input  logic                       ev_on,
  input  logic [7:0]                 ev_key,
  input  logic [15:0]                ev_freq,
  output logic [16*NUM_VOICES-1:0]   voice_freq,
  output logic [31*NUM_VOICES-1:0]   voice_amp,
  output logic [NUM_VOICES-1:0]      voice_active,
  output logic                       steal_pulse
);

  localparam int unsigned IdxW = $clog2(NUM_VOICES);
  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  typedef enum logic [1:0] {VFree, VAttack, VSustain, VRelease} vstate_e;
  typedef enum logic [1:0] {StIdle, StLookup, StCommit} ctrl_e;
  typedef enum logic [2:0] {ActNone, ActRetrig, ActAlloc, ActSteal, ActRelease} act_e;

  ctrl_e                         ctrl_q, ctrl_d;
  act_e                          act_q, act_d;
  logic [IdxW-1:0]               tgt_q, tgt_d;
  logic                          ev_on_q;
  logic [7:0]                    ev_key_q;
  logic [15:0]                   ev_freq_q;
  logic [CntW-1:0]               cnt_q;
  logic                          steal_q;
  logic                          tick;

  vstate_e [NUM_VOICES-1:0]       vst_q, vst_d;
  logic [NUM_VOICES-1:0][30:0]    amp_q, amp_d;
  logic [NUM_VOICES-1:0][15:0]    freq_q, freq_d;
  logic [NUM_VOICES-1:0][7:0]     key_q, key_d;
  logic [NUM_VOICES-1:0][7:0]     age_q, age_d;
  logic [NUM_VOICES-1:0][31:0]    att_sum;

  logic            match_found, free_found;
  logic [IdxW-1:0] match_idx, free_idx, old_idx;
  logic [7:0]      old_age;

  assign tick     = (cnt_q == CntMax);
  assign ev_ready = (ctrl_q == StIdle);

  always_comb begin
    ctrl_d = ctrl_q;
    unique case (ctrl_q)
      StIdle:   if (ev_valid) ctrl_d = StLookup;
      StLookup: ctrl_d = StCommit;
      StCommit: ctrl_d = StIdle;
      default:  ctrl_d = StIdle;
    endcase
  end

  // Descending scan leaves the lowest-index free voice; strict > keeps the lowest on age ties.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (vst_q[i] != VFree && key_q[i] == ev_key_q) begin
        match_found = 1'b1;
        match_idx   = IdxW'(i);
      end
      if (vst_q[i] == VFree) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
    old_idx = '0;
    old_age = age_q[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_q[i] > old_age) begin
        old_idx = IdxW'(i);
        old_age = age_q[i];
      end
    end
  end

  always_comb begin
    act_d = ActNone;
    tgt_d = '0;
    if (ev_on_q) begin
      if (ev_freq_q != '0) begin
        if (match_found) begin
          act_d = ActRetrig;
          tgt_d = match_idx;
        end else if (free_found) begin
          act_d = ActAlloc;
          tgt_d = free_idx;
        end else begin
          act_d = ActSteal;
          tgt_d = old_idx;
        end
      end
    end else if (match_found && vst_q[match_idx] != VRelease) begin
      act_d = ActRelease;
      tgt_d = match_idx;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      att_sum[i] = {1'b0, amp_q[i]} + {1'b0, AMP_STEP};
    end
  end

  always_comb begin
    vst_d  = vst_q;
    amp_d  = amp_q;
    freq_d = freq_q;
    key_d  = key_q;
    age_d  = age_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (tick && vst_q[i] != VFree) begin
        age_d[i] = (age_q[i] == 8'hFF) ? 8'hFF : age_q[i] + 8'd1;
        case (vst_q[i])
          VAttack: begin
            if (att_sum[i] >= {1'b0, AMP_MAX}) begin
              amp_d[i] = AMP_MAX;
              vst_d[i] = VSustain;
            end else begin
              amp_d[i] = att_sum[i][30:0];
            end
          end
          VRelease: begin
            if (amp_q[i] <= AMP_STEP) begin
              amp_d[i] = '0;
              vst_d[i] = VFree;
            end else begin
              amp_d[i] = amp_q[i] - AMP_STEP;
            end
          end
          default: ;
        endcase
      end
    end
    // The voice written by COMMIT overrides its own tick update.
    if (ctrl_q == StCommit) begin
      case (act_q)
        ActRetrig: begin
          vst_d[tgt_q]  = VAttack;
          amp_d[tgt_q]  = amp_q[tgt_q];
          freq_d[tgt_q] = ev_freq_q;
          age_d[tgt_q]  = '0;
        end
        ActAlloc, ActSteal: begin
          vst_d[tgt_q]  = VAttack;
          amp_d[tgt_q]  = '0;
          freq_d[tgt_q] = ev_freq_q;
          key_d[tgt_q]  = ev_key_q;
          age_d[tgt_q]  = '0;
        end
        ActRelease: begin
          vst_d[tgt_q] = VRelease;
          amp_d[tgt_q] = amp_q[tgt_q];
          age_d[tgt_q] = age_q[tgt_q];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q    <= StIdle;
      act_q     <= ActNone;
      tgt_q     <= '0;
      ev_on_q   <= 1'b0;
      ev_key_q  <= '0;
      ev_freq_q <= '0;
      cnt_q     <= '0;
      steal_q   <= 1'b0;
      vst_q     <= {NUM_VOICES{VFree}};
      amp_q     <= '0;
      freq_q    <= '0;
      key_q     <= '0;
      age_q     <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      cnt_q   <= tick ? '0 : cnt_q + 1'b1;
      steal_q <= (ctrl_q == StCommit) && (act_q == ActSteal);
      if (ctrl_q == StIdle && ev_valid) begin
        ev_on_q   <= ev_on;
        ev_key_q  <= ev_key;
        ev_freq_q <= ev_freq;
      end
      if (ctrl_q == StLookup) begin
        act_q <= act_d;
        tgt_q <= tgt_d;
      end
      vst_q  <= vst_d;
      amp_q  <= amp_d;
      freq_q <= freq_d;
      key_q  <= key_d;
      age_q  <= age_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_freq[16*i +: 16] = (vst_q[i] != VFree) ? freq_q[i] : 16'd0;
      voice_amp[31*i +: 31]  = amp_q[i];
      voice_active[i]        = (vst_q[i] != VFree);
    end
  end

  assign steal_pulse = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator with a short envelope tick.
module tb_voice_allocator;

  localparam int unsigned NV = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            ev_valid = 1'b0;
  logic            ev_ready;
  logic            ev_on = 1'b0;
  logic [7:0]      ev_key = '0;
  logic [15:0]     ev_freq = '0;
  logic [16*NV-1:0] voice_freq;
  logic [31*NV-1:0] voice_amp;
  logic [NV-1:0]   voice_active;
  logic            steal_pulse;

  int checks = 0;
  int failures = 0;

  voice_allocator #(
    .NUM_VOICES (NV),
    .TICK_DIV   (4),
    .AMP_MAX    (31'd100),
    .AMP_STEP   (31'd25)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_key       (ev_key),
    .ev_freq      (ev_freq),
    .voice_freq   (voice_freq),
    .voice_amp    (voice_amp),
    .voice_active (voice_active),
    .steal_pulse  (steal_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] amp_of(input int v);
    return voice_amp[31*v +: 31];
  endfunction

  function automatic logic [15:0] freq_of(input int v);
    return voice_freq[16*v +: 16];
  endfunction

  // Returns at the negedge after the COMMIT edge, where outputs reflect the event.
  task automatic send(input logic on, input logic [7:0] key, input logic [15:0] freq);
    int n;
    n = 0;
    @(negedge clk);
    while (!ev_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ev_ready) begin
      $display("FAIL send_ready_timeout: ev_ready=%0b expected 1", ev_ready);
      failures++;
    end
    ev_valid = 1'b1;
    ev_on    = on;
    ev_key   = key;
    ev_freq  = freq;
    @(posedge clk);
    #1 ev_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_amp_change(input int v, input logic [30:0] prev,
                                 output logic [30:0] now, output logic ok);
    ok  = 1'b0;
    now = prev;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      now = amp_of(v);
      if (now !== prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ev_ready !== 1'b1) begin
      $display("FAIL reset_ready: got %0b expected 1", ev_ready); failures++;
    end
    checks++;
    if (voice_active !== 4'b0000) begin
      $display("FAIL reset_active: got %b expected 0000", voice_active); failures++;
    end
    checks++;
    if (voice_freq !== '0) begin
      $display("FAIL reset_freq: got %h expected 0", voice_freq); failures++;
    end
    checks++;
    if (voice_amp !== '0) begin
      $display("FAIL reset_amp: got %h expected 0", voice_amp); failures++;
    end
    checks++;
    if (steal_pulse !== 1'b0) begin
      $display("FAIL reset_steal: got %0b expected 0", steal_pulse); failures++;
    end
  endtask

  task automatic test_attack();
    logic [30:0] exp_amp [4] = '{31'd25, 31'd50, 31'd75, 31'd100};
    logic [30:0] prev, now;
    logic        ok;
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 8'h1C; ev_freq = 16'd440;
    @(posedge clk);
    #1 ev_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ev_ready !== 1'b0) begin
      $display("FAIL attack_ready_lookup: got %0b expected 0", ev_ready); failures++;
    end
    @(negedge clk);
    checks++;
    if (ev_ready !== 1'b0) begin
      $display("FAIL attack_ready_commit: got %0b expected 0", ev_ready); failures++;
    end
    @(negedge clk);
    checks++;
    if (ev_ready !== 1'b1 || freq_of(0) !== 16'd440 || voice_active !== 4'b0001
        || amp_of(0) !== 31'd0) begin
      $display("FAIL attack_alloc: ready=%0b freq0=%0d active=%b amp0=%0d expected 1/440/0001/0",
               ev_ready, freq_of(0), voice_active, amp_of(0));
      failures++;
    end
    prev = amp_of(0);
    for (int k = 0; k < 4; k++) begin
      wait_amp_change(0, prev, now, ok);
      checks++;
      if (!ok || now !== exp_amp[k]) begin
        $display("FAIL attack_step%0d: amp0=%0d expected %0d", k, now, exp_amp[k]);
        failures++;
      end
      prev = now;
    end
    repeat (12) @(negedge clk);
    checks++;
    if (amp_of(0) !== 31'd100 || voice_active !== 4'b0001) begin
      $display("FAIL sustain_hold: amp0=%0d active=%b expected 100/0001", amp_of(0), voice_active);
      failures++;
    end
  endtask

  task automatic test_release();
    logic [30:0] exp_amp [4] = '{31'd75, 31'd50, 31'd25, 31'd0};
    logic [30:0] prev, now;
    logic        ok;
    send(1'b0, 8'h1C, 16'd0);
    checks++;
    if (amp_of(0) !== 31'd100 || voice_active !== 4'b0001) begin
      $display("FAIL release_start: amp0=%0d active=%b expected 100/0001", amp_of(0), voice_active);
      failures++;
    end
    prev = amp_of(0);
    for (int k = 0; k < 4; k++) begin
      wait_amp_change(0, prev, now, ok);
      checks++;
      if (!ok || now !== exp_amp[k]) begin
        $display("FAIL release_step%0d: amp0=%0d expected %0d", k, now, exp_amp[k]);
        failures++;
      end
      prev = now;
    end
    checks++;
    if (voice_active[0] !== 1'b0 || freq_of(0) !== 16'd0) begin
      $display("FAIL release_free: active0=%0b freq0=%0d expected 0/0", voice_active[0], freq_of(0));
      failures++;
    end
  endtask

  task automatic test_steal();
    send(1'b1, 8'd1, 16'd262);
    send(1'b1, 8'd2, 16'd294);
    send(1'b1, 8'd3, 16'd330);
    send(1'b1, 8'd4, 16'd349);
    checks++;
    if (voice_active !== 4'b1111 || voice_freq !== {16'd349, 16'd330, 16'd294, 16'd262}) begin
      $display("FAIL steal_fill: active=%b freq=%h expected 1111/015d014a01260106",
               voice_active, voice_freq);
      failures++;
    end
    checks++;
    if (steal_pulse !== 1'b0) begin
      $display("FAIL steal_no_pulse: got %0b expected 0", steal_pulse); failures++;
    end
    send(1'b1, 8'd5, 16'd392);
    checks++;
    if (freq_of(0) !== 16'd392 || amp_of(0) !== 31'd0 || steal_pulse !== 1'b1) begin
      $display("FAIL steal_voice0: freq0=%0d amp0=%0d steal=%0b expected 392/0/1",
               freq_of(0), amp_of(0), steal_pulse);
      failures++;
    end
    checks++;
    if (freq_of(1) !== 16'd294 || voice_active !== 4'b1111) begin
      $display("FAIL steal_others: freq1=%0d active=%b expected 294/1111", freq_of(1), voice_active);
      failures++;
    end
    @(negedge clk);
    checks++;
    if (steal_pulse !== 1'b0) begin
      $display("FAIL steal_one_cycle: got %0b expected 0", steal_pulse); failures++;
    end
  endtask

  task automatic test_retrigger();
    int n;
    do_reset();
    send(1'b1, 8'h1C, 16'd440);
    n = 0;
    while (amp_of(0) !== 31'd100 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (amp_of(0) !== 31'd100) begin
      $display("FAIL retrig_sustain_wait: amp0=%0d expected 100", amp_of(0)); failures++;
    end
    send(1'b1, 8'h1C, 16'd880);
    checks++;
    if (freq_of(0) !== 16'd880 || amp_of(0) !== 31'd100 || voice_active !== 4'b0001) begin
      $display("FAIL retrig_voice0: freq0=%0d amp0=%0d active=%b expected 880/100/0001",
               freq_of(0), amp_of(0), voice_active);
      failures++;
    end
    checks++;
    if (steal_pulse !== 1'b0 || freq_of(1) !== 16'd0) begin
      $display("FAIL retrig_no_steal: steal=%0b freq1=%0d expected 0/0", steal_pulse, freq_of(1));
      failures++;
    end
  endtask

  task automatic test_reset_mid_and_ignored();
    int n;
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 8'h20; ev_freq = 16'd600;
    @(posedge clk);
    #1 ev_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ev_ready !== 1'b1 || voice_active !== 4'b0000 || voice_freq !== '0) begin
      $display("FAIL midreset_state: ready=%0b active=%b freq=%h expected 1/0000/0",
               ev_ready, voice_active, voice_freq);
      failures++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (voice_active !== 4'b0000 || voice_freq !== '0 || voice_amp !== '0) begin
      $display("FAIL midreset_aborted: active=%b freq=%h amp=%h expected all 0",
               voice_active, voice_freq, voice_amp);
      failures++;
    end
    send(1'b1, 8'h30, 16'd500);
    n = 0;
    while (amp_of(0) !== 31'd100 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (amp_of(0) !== 31'd100 || freq_of(0) !== 16'd500) begin
      $display("FAIL ignore_setup: amp0=%0d freq0=%0d expected 100/500", amp_of(0), freq_of(0));
      failures++;
    end
    send(1'b0, 8'h31, 16'd0);
    checks++;
    if (voice_active !== 4'b0001 || voice_freq !== {48'd0, 16'd500}
        || voice_amp !== {93'd0, 31'd100}) begin
      $display("FAIL ignore_noteoff: active=%b freq=%h amp=%h expected 0001/500/100",
               voice_active, voice_freq, voice_amp);
      failures++;
    end
    send(1'b1, 8'h32, 16'd0);
    repeat (5) @(negedge clk);
    checks++;
    if (voice_active !== 4'b0001 || voice_freq !== {48'd0, 16'd500}
        || voice_amp !== {93'd0, 31'd100} || steal_pulse !== 1'b0) begin
      $display("FAIL ignore_freq0: active=%b freq=%h amp=%h steal=%0b expected 0001/500/100/0",
               voice_active, voice_freq, voice_amp, steal_pulse);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_release();
    test_steal();
    test_retrigger();
    test_reset_mid_and_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
